// File: rtl/clk_gate_ctrl.sv
// Multi-channel activity-driven clock-gating controller.
// Each channel owns an idle counter, an ON/OFF enable and a low-transparent ICG latch.
module clk_gate_ctrl #(
  parameter int N_CH        = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] ACT,
  input  logic [N_CH-1:0] CH_DIS,
  input  logic            TEST_EN,
  output logic [N_CH-1:0] GCLK,
  output logic [N_CH-1:0] CH_ON,
  output logic [N_CH-1:0] WAKE
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic             en_q;
      logic             en_d;
      logic             wake_q;
      logic             wake_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             lat_en;

      // State register
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          en_q   <= 1'b1;
          cnt_q  <= '0;
          wake_q <= 1'b0;
        end else begin
          en_q   <= en_d;
          cnt_q  <= cnt_d;
          wake_q <= wake_d;
        end
      end

      // Next state: software disable beats activity, activity beats idle timeout
      always_comb begin
        en_d   = en_q;
        cnt_d  = cnt_q;
        wake_d = 1'b0;
        if (CH_DIS[gi]) begin
          en_d  = 1'b0;
          cnt_d = '0;
        end else if (en_q) begin
          if (ACT[gi]) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            en_d  = 1'b0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (ACT[gi]) begin
          en_d   = 1'b1;
          cnt_d  = '0;
          wake_d = 1'b1;
        end
      end

      // Enable only moves while CLK is low, so a gated pulse is never clipped
      always_latch begin
        if (!CLK) lat_en = en_q | TEST_EN;
      end

      // Outputs
      assign GCLK[gi]  = CLK & lat_en;
      assign CH_ON[gi] = en_q;
      assign WAKE[gi]  = wake_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized traffic
// compared against a per-channel idle-run model.
`timescale 1ns/1ps
module tb_clk_gate_ctrl;

  localparam int N    = 4;
  localparam int IDLE = 8;
  localparam int HALF = 5;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] ACT = '0;
  logic [N-1:0] CH_DIS = '0;
  logic         TEST_EN = 1'b0;
  logic [N-1:0] GCLK;
  logic [N-1:0] CH_ON;
  logic [N-1:0] WAKE;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: ON flag plus the number of idle samples seen while ON
  logic [N-1:0] m_on   = '1;
  logic [N-1:0] m_wake = '0;
  int           m_idle [N];

  clk_gate_ctrl #(.N_CH(N), .IDLE_CYCLES(IDLE)) dut (
    .CLK(CLK), .RST(RST), .ACT(ACT), .CH_DIS(CH_DIS), .TEST_EN(TEST_EN),
    .GCLK(GCLK), .CH_ON(CH_ON), .WAKE(WAKE)
  );

  always #HALF CLK = ~CLK;

  // Every gated pulse must start on a CLK rising edge and last a full high phase
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mon
      time rise_t = 0;
      bit  seen   = 1'b0;
      always @(posedge GCLK[gi]) begin
        n_cmp++;
        if (CLK !== 1'b1) begin
          n_err++;
          $display("FAIL gclk_rise_phase ch%0d: CLK=%b at GCLK rise, required 1", gi, CLK);
        end
        rise_t = $time;
        seen   = 1'b1;
      end
      always @(negedge GCLK[gi]) begin
        if (seen) begin
          n_cmp++;
          if ($time - rise_t != HALF) begin
            n_err++;
            $display("FAIL gclk_width ch%0d: high for %0t, required %0d", gi, $time - rise_t, HALF);
          end
        end
      end
    end
  endgenerate

  task automatic model_reset();
    m_on   = '1;
    m_wake = '0;
    for (int i = 0; i < N; i++) m_idle[i] = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] a, input logic [N-1:0] d);
    for (int i = 0; i < N; i++) begin
      m_wake[i] = 1'b0;
      if (d[i]) begin
        m_on[i] = 1'b0; m_idle[i] = 0;
      end else if (m_on[i]) begin
        if (a[i]) m_idle[i] = 0;
        else begin
          m_idle[i]++;
          if (m_idle[i] >= IDLE) begin m_on[i] = 1'b0; m_idle[i] = 0; end
        end
      end else if (a[i]) begin
        m_on[i] = 1'b1; m_wake[i] = 1'b1; m_idle[i] = 0;
      end
    end
  endtask

  // Called in the low phase; returns 1ns after the rising edge
  task automatic step_rise(input logic [N-1:0] a, input logic [N-1:0] d, input logic t);
    logic [N-1:0] exp_g;
    ACT = a; CH_DIS = d; TEST_EN = t;
    #1;
    n_cmp++;
    if (GCLK !== '0) begin
      n_err++;
      $display("FAIL gclk_low_phase: GCLK=%b, required 0000", GCLK);
    end
    exp_g = m_on | {N{t}};
    @(posedge CLK);
    model_edge(a, d);
    #1;
    n_cmp++;
    if (GCLK !== exp_g) begin
      n_err++;
      $display("FAIL gclk_high t=%0t: GCLK=%b, required %b", $time, GCLK, exp_g);
    end
    n_cmp++;
    if (CH_ON !== m_on) begin
      n_err++;
      $display("FAIL ch_on t=%0t: CH_ON=%b, required %b", $time, CH_ON, m_on);
    end
    n_cmp++;
    if (WAKE !== m_wake) begin
      n_err++;
      $display("FAIL wake t=%0t: WAKE=%b, required %b", $time, WAKE, m_wake);
    end
  endtask

  task automatic step(input logic [N-1:0] a, input logic [N-1:0] d, input logic t);
    step_rise(a, d, t);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 RST = 1'b0;
    #1;
    n_cmp++;
    if (CH_ON !== 4'hF) begin
      n_err++; $display("FAIL reset_ch_on: CH_ON=%b, required 1111", CH_ON);
    end
    n_cmp++;
    if (WAKE !== 4'h0) begin
      n_err++; $display("FAIL reset_wake: WAKE=%b, required 0000", WAKE);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (GCLK !== 4'hF) begin
      n_err++; $display("FAIL reset_gclk: GCLK=%b, required 1111", GCLK);
    end
    @(negedge CLK); #1;
    RST = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_idle_gateoff();
    for (int k = 1; k <= IDLE + 1; k++) step('0, '0, 1'b0);
    n_cmp++;
    if (CH_ON !== 4'h0) begin
      n_err++; $display("FAIL idle_gateoff: CH_ON=%b, required 0000", CH_ON);
    end
    $display("test_idle_gateoff done");
  endtask

  task automatic test_wake();
    step_rise(4'b0100, '0, 1'b0);
    n_cmp++;
    if (WAKE !== 4'b0100) begin
      n_err++; $display("FAIL wake_pulse: WAKE=%b, required 0100", WAKE);
    end
    @(negedge CLK);
    step_rise('0, '0, 1'b0);
    n_cmp++;
    if (GCLK !== 4'b0100 || WAKE !== 4'b0000) begin
      n_err++; $display("FAIL wake_follow: GCLK=%b WAKE=%b, required 0100/0000", GCLK, WAKE);
    end
    @(negedge CLK);
    $display("test_wake done");
  endtask

  task automatic test_keepalive();
    step('0, '1, 1'b0);
    step(4'b0001, '0, 1'b0);
    repeat (5) begin
      repeat (IDLE - 2) step('0, '0, 1'b0);
      step(4'b0001, '0, 1'b0);
    end
    n_cmp++;
    if (CH_ON[0] !== 1'b1) begin
      n_err++; $display("FAIL keepalive: CH_ON[0]=%b, required 1", CH_ON[0]);
    end
    repeat (IDLE) step('0, '0, 1'b0);
    n_cmp++;
    if (CH_ON[0] !== 1'b0) begin
      n_err++; $display("FAIL keepalive_off: CH_ON[0]=%b, required 0", CH_ON[0]);
    end
    $display("test_keepalive done");
  endtask

  task automatic test_ch_dis();
    step(4'b0010, '0, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);
    n_cmp++;
    if (CH_ON[1] !== 1'b0 || WAKE[1] !== 1'b0) begin
      n_err++; $display("FAIL ch_dis: CH_ON[1]=%b WAKE[1]=%b, required 0/0", CH_ON[1], WAKE[1]);
    end
    repeat (3) step('0, '0, 1'b0);
    step(4'b0010, '0, 1'b0);
    $display("test_ch_dis done");
  endtask

  task automatic test_test_en();
    step('0, '1, 1'b0);
    step('0, '0, 1'b0);
    repeat (4) step('0, '0, 1'b1);
    repeat (3) step('0, '0, 1'b0);
    $display("test_test_en done");
  endtask

  task automatic test_random();
    logic [N-1:0] a, d;
    logic         t;
    t = 1'b0;
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(0, 5) == 0);
        d[i] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 24) == 0) t = ~t;
      step(a, d, t);
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    step('0, '1, 1'b0);
    step_rise('0, '0, 1'b0);
    #1 RST = 1'b0;
    #1;
    n_cmp++;
    if (CH_ON !== 4'hF) begin
      n_err++; $display("FAIL reset_mid_ch_on: CH_ON=%b, required 1111", CH_ON);
    end
    n_cmp++;
    if (GCLK !== 4'h0) begin
      n_err++; $display("FAIL reset_mid_gclk: GCLK=%b, required 0000", GCLK);
    end
    @(negedge CLK); #1;
    RST = 1'b1;
    model_reset();
    repeat (3) step('0, '0, 1'b0);
    $display("test_reset_mid done");
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_idle[i] = 0;
    test_reset();
    test_idle_gateoff();
    test_wake();
    test_keepalive();
    test_ch_dis();
    test_test_en();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Parametrised, multi-channel, activity-driven clock-gating controller. Each of `N_CH` channels receives a gated copy of `CLK`. A channel gates itself off after `IDLE_CYCLES` consecutive idle cycles and wakes on the next activity. Gating uses a latch-based integrated clock gate, so the gated clocks are glitch-free. The block sits at the clock-distribution level, in front of register banks that only need clocking while busy; a scan/test override and a per-channel software disable are provided.

## Interface
Parameters:
- `N_CH`, default 4: number of gated channels (≥1).
- `IDLE_CYCLES`, default 8: consecutive idle samples before gate-off (≥1).
- `CNT_W`, default `$clog2(IDLE_CYCLES+1)`: idle-counter width; derived, not overridden.

Ports:
- `CLK`, in, 1: source clock. One clock domain only.
- `RST`, in, 1: reset, asynchronous, active-low.
- `ACT`, in, N_CH: per-channel activity; synchronous to `CLK`.
- `CH_DIS`, in, N_CH: per-channel software disable; synchronous to `CLK`.
- `TEST_EN`, in, 1: global override; forces all gates open.
- `GCLK`, out, N_CH: gated clocks, `GCLK[i] = CLK & lat_en[i]`.
- `CH_ON`, out, N_CH: registered per-channel enable (`en_q`), exported as status.
- `WAKE`, out, N_CH: one-cycle pulse on an OFF→ON transition.

## Operation
- Per channel: state register `en_q` (ON=1 / OFF=0), idle counter `cnt` (`CNT_W` bits), enable latch `lat_en`.
- `lat_en` is transparent while `CLK`=0 and holds while `CLK`=1. Its data input is `en_q | TEST_EN`. There is no combinational path from `ACT`/`CH_DIS` to `GCLK`.
- State updates occur on posedge `CLK`, in priority order:
  1. `CH_DIS[i]`=1: `en_q`←0, `cnt`←0.
  2. ON and `ACT[i]`=1: `cnt`←0, stay ON.
  3. ON, `ACT[i]`=0, `cnt`=IDLE_CYCLES-1: `en_q`←0, `cnt`←0.
  4. ON, `ACT[i]`=0 otherwise: `cnt`←`cnt`+1.
  5. OFF and `ACT[i]`=1: `en_q`←1, `cnt`←0, `WAKE[i]`←1.
  6. OFF and `ACT[i]`=0: hold.
- `WAKE[i]` is registered and is 0 in every cycle except the one following rule 5.
- `cnt` never exceeds IDLE_CYCLES-1; no wrap-around is possible.
- `TEST_EN` does not alter `en_q`, `cnt`, `CH_ON` or `WAKE`; it only opens the latch. Idle tracking continues underneath it.
- Releasing `CH_DIS` leaves the channel OFF until the next `ACT`.
- `ACT` high while `CH_DIS` is high: the channel stays OFF and `WAKE` stays 0.
- Channels are fully independent; there is no cross-channel arbitration.

## Timing
- Reset (`RST`=0, async): `en_q`←1, `cnt`←0, `WAKE`←0, so `CH_ON`=all-ones. `lat_en` follows `en_q` on the next low phase, so `GCLK` toggles with `CLK` from the first low phase during reset.
- Reset mid-operation: all channels return to ON immediately and counters clear. A latch holding 0 during a high phase opens on the following low phase, with no partial pulse.
- Wake latency: `ACT` sampled 1 at edge k in OFF gives `en_q`=1 after k, and the first `GCLK` rising edge is at edge k+1. `ACT` itself is never clocked by the gated clock at edge k.
- Gate-off: `ACT`=0 sampled at edges k … k+IDLE_CYCLES-1 with the channel ON gives `en_q`=0 after edge k+IDLE_CYCLES-1. The last `GCLK` pulse is at that edge; there is no pulse at k+IDLE_CYCLES.
- `CH_DIS` sampled at edge k: the last `GCLK` pulse is at edge k and `CH_ON` falls after k.
- `TEST_EN`: takes effect on the next `CLK` low phase. It is intended to be static during scan.
- `GCLK` is never truncated: enable changes only propagate while `CLK` is low.

## Test plan
- Reset release with `ACT`=0, IDLE_CYCLES=8 → `CH_ON`=4'hF and `GCLK` toggles for 8 edges. `CH_ON` falls after the 8th edge, and the 9th edge has no `GCLK` pulse on any channel.
- Channel 2 OFF, `ACT[2]`=1 for one cycle at edge k → `WAKE[2]`=1 for exactly one cycle after k, and `GCLK[2]` rises at k+1. Channels 0, 1 and 3 are unaffected.
- Channel ON, `ACT` pulsed every 7 cycles (IDLE_CYCLES=8) → the channel never gates off and `cnt` peaks at 6. Stretching the gap to 8 idle samples → gate-off.
- `CH_DIS[1]`=1 together with `ACT[1]`=1 → `CH_ON[1]`=0 after that edge and `WAKE[1]` stays 0. After releasing `CH_DIS`, the channel stays OFF until `ACT[1]`=1.
- `TEST_EN`=1 with all channels OFF → all `GCLK` toggle from the next low phase while `CH_ON` stays 0. Clearing `TEST_EN` → gating resumes with no glitch or shortened high pulse, checked by a pulse-width assertion.
- `RST` asserted mid-high-phase with channels OFF → `CH_ON`=all-ones asynchronously. The first `GCLK` pulse is full-width at the following rising edge.
